keypad_entry: RTL

Code-entry front end for the digital lock. It accepts single keypad events (a hex digit, clear, backspace or enter) and assembles them into a four-nibble code. On enter, it presents the code to the lock's `digit_1`..`digit_4` inputs together with a one-cycle strobe. It sits between the keypad scanner and the lock and drives the lock's code inputs.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/entry_timer.sv | 30 +++
 rtl/keypad_entry.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad code-entry front end: key commands,
// entry FSM states and the buffered code layout.
package keypad_pkg;

  localparam int CODE_DIGITS = 4;

  typedef enum logic [1:0] {
    KEY_DIGIT = 2'd0,
    KEY_CLEAR = 2'd1,
    KEY_BACK  = 2'd2,
    KEY_ENTER = 2'd3
  } key_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2,
    ST_SEND  = 2'd3
  } state_e;

  // Element [CODE_DIGITS-1] holds the first entered (most significant) nibble.
  typedef logic [CODE_DIGITS-1:0][3:0] code_t;

endpackage

// File: rtl/entry_timer.sv
// Inactivity counter for a partial code entry: held at zero while not running,
// restarted by clear_i, and pulses expire_o when it reaches LIMIT cycles.
module entry_timer #(
  parameter int unsigned LIMIT = 1000,
  parameter int unsigned TW    = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Expiry depends only on the registered count so a same-cycle key can
  // still be processed against the cleared entry without a loop.
  assign expire_o = run_i && (cnt_q == TW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (!run_i || clear_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_entry.sv
// Assembles keypad events into a four-nibble code and presents it to the lock
// with a one-cycle strobe. Optional idle timeout: `define KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TW             = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [1:0] key_cmd,
  input  logic [3:0] key_val,
  input  logic       lock_busy,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_4,
  output logic       code_valid,
  output logic [2:0] entry_count,
  output logic       key_err
);

  if ((64'd1 << TW) <= 64'(TIMEOUT_CYCLES)) begin : g_tw_too_narrow
    $error("keypad_entry: TW too narrow for TIMEOUT_CYCLES");
  end

  state_e     state_q, state_d;
  code_t      buf_q, buf_d;
  code_t      hold_q, hold_d;
  code_t      pres_q, pres_d;
  logic [2:0] cnt_q, cnt_d;
  logic       code_valid_q, code_valid_d;
  logic       key_err_q, key_err_d;
  logic [1:0] slot;
  logic       expire;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  logic key_taken;

  // Every processed key restarts the idle count except a digit rejected in FULL.
  assign key_taken = key_valid && !lock_busy &&
                     !(key_cmd_e'(key_cmd) == KEY_DIGIT && state_q == ST_FULL && !expire);

  entry_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .TW    (TW)
  ) u_entry_timer (
    .clk      (clk),
    .reset    (reset),
    .run_i    (state_q == ST_ENTRY || state_q == ST_FULL),
    .clear_i  (key_taken),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // NOTE: every variable gets its default before any branch so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    pres_d       = pres_q;
    code_valid_d = 1'b0;
    key_err_d    = 1'b0;
    slot         = 2'd0;

    if (expire) begin
      state_d   = ST_IDLE;
      buf_d     = '0;
      cnt_d     = '0;
      key_err_d = 1'b1;
    end

    if (state_q == ST_SEND) begin
      state_d      = ST_IDLE;
      pres_d       = hold_q;
      code_valid_d = 1'b1;
      if (key_valid && !lock_busy) key_err_d = 1'b1;
    end else if (key_valid && !lock_busy) begin
      unique case (key_cmd_e'(key_cmd))
        KEY_DIGIT: begin
          if (cnt_d == 3'd4) begin
            key_err_d = 1'b1;
          end else begin
            slot        = 2'd3 - cnt_d[1:0];
            buf_d[slot] = key_val;
            cnt_d       = cnt_d + 3'd1;
            state_d     = (cnt_d == 3'd4) ? ST_FULL : ST_ENTRY;
          end
        end
        KEY_CLEAR: begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        KEY_BACK: begin
          if (cnt_d != 3'd0) begin
            cnt_d       = cnt_d - 3'd1;
            slot        = 2'd3 - cnt_d[1:0];
            buf_d[slot] = 4'h0;
            state_d     = (cnt_d == 3'd0) ? ST_IDLE : ST_ENTRY;
          end
        end
        KEY_ENTER: begin
          if (cnt_d == 3'd4) begin
            hold_d  = buf_d;
            state_d = ST_SEND;
          end else begin
            key_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
          buf_d = '0;
          cnt_d = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      hold_q       <= '0;
      pres_q       <= '0;
      cnt_q        <= '0;
      code_valid_q <= 1'b0;
      key_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      hold_q       <= hold_d;
      pres_q       <= pres_d;
      cnt_q        <= cnt_d;
      code_valid_q <= code_valid_d;
      key_err_q    <= key_err_d;
    end
  end

  assign digit_1     = pres_q[3];
  assign digit_2     = pres_q[2];
  assign digit_3     = pres_q[1];
  assign digit_4     = pres_q[0];
  assign code_valid  = code_valid_q;
  assign entry_count = cnt_q;
  assign key_err     = key_err_q;

endmodule
